// File: rtl/hazard_sched_ctrl_if.sv
// ============================================================================
// Module  : hazard_sched_ctrl_if
// Brief   : Pipeline-side hazard information and hazard-control outputs.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface hazard_sched_ctrl_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] rs1D;
    logic [REG_AW-1:0] rs2D;
    logic [REG_AW-1:0] rs1E;
    logic [REG_AW-1:0] rs2E;
    logic [REG_AW-1:0] rdE;
    logic              mem_readE;
    logic              mdu_startE;
    logic              mdu_done;
    logic              PCSE;
    logic [REG_AW-1:0] rdM;
    logic [REG_AW-1:0] rdW;
    logic              reg_writeM;
    logic              reg_writeW;

    logic              stallF;
    logic              stallD;
    logic              stallE;
    logic              flushD;
    logic              flushE;
    logic              flushM;
    logic [1:0]        forwardAE;
    logic [1:0]        forwardBE;
    logic              mdu_busy;
    logic              mdu_timeout;

    modport master (
        output rs1D, rs2D, rs1E, rs2E, rdE, mem_readE, mdu_startE, mdu_done,
               PCSE, rdM, rdW, reg_writeM, reg_writeW,
        input  stallF, stallD, stallE, flushD, flushE, flushM,
               forwardAE, forwardBE, mdu_busy, mdu_timeout
    );

    modport slave (
        input  rs1D, rs2D, rs1E, rs2E, rdE, mem_readE, mdu_startE, mdu_done,
               PCSE, rdM, rdW, reg_writeM, reg_writeW,
        output stallF, stallD, stallE, flushD, flushE, flushM,
               forwardAE, forwardBE, mdu_busy, mdu_timeout
    );
endinterface

`default_nettype wire

// File: rtl/hazard_sched_ctrl.sv
// ============================================================================
// Module  : hazard_sched_ctrl
// Brief   : 5-stage RV32 hazard scheduler (forwarding, load-use, redirect,
//           MDU wait with watchdog). Optional HAZARD_PERF_CNT_EN adds counters.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_sched_ctrl #(
    parameter int REG_AW      = 5,
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 7
) (
    input  wire                clk,
    input  wire                rst,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_flush_cnt,
`endif
    hazard_sched_ctrl_if.slave hz
);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MDU_WAIT = 1'b1
    } state_t;

    localparam logic [REG_AW-1:0] c_X0       = '0;
    localparam logic [CNT_W-1:0]  c_CNT_LAST = CNT_W'(MDU_TIMEOUT - 1);

    state_t             r_state_q, w_state_d;
    logic [CNT_W-1:0]   r_cnt_q,   w_cnt_d;
    logic               r_tmo_q,   w_tmo_d;

    logic               w_stallF, w_stallD, w_stallE;
    logic               w_flushD, w_flushE, w_flushM;
    logic [1:0]         w_fwd_a,  w_fwd_b;
    logic               w_lu;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic              wr_m,
        input logic [REG_AW-1:0] rd_m,
        input logic              wr_w,
        input logic [REG_AW-1:0] rd_w
    );
        if (wr_m && rd_m != c_X0 && rd_m == rs)      return 2'b10;
        else if (wr_w && rd_w != c_X0 && rd_w == rs) return 2'b01;
        else                                         return 2'b00;
    endfunction

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_tmo_d   = r_tmo_q;
        w_stallF  = 1'b0;
        w_stallD  = 1'b0;
        w_stallE  = 1'b0;
        w_flushD  = 1'b0;
        w_flushE  = 1'b0;
        w_flushM  = 1'b0;
        w_fwd_a   = fwd_sel(hz.rs1E, hz.reg_writeM, hz.rdM, hz.reg_writeW, hz.rdW);
        w_fwd_b   = fwd_sel(hz.rs2E, hz.reg_writeM, hz.rdM, hz.reg_writeW, hz.rdW);
        w_lu      = hz.mem_readE && (hz.rdE != c_X0) &&
                    ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));

        case (r_state_q)
            ST_RUN: begin
                // Redirect first: the Decode instruction is wrong-path, so
                // a load-use or MDU start paired with it is discarded.
                if (hz.PCSE) begin
                    w_flushD = 1'b1;
                    w_flushE = 1'b1;
                end else if (hz.mdu_startE) begin
                    w_stallF  = 1'b1;
                    w_stallD  = 1'b1;
                    w_stallE  = 1'b1;
                    w_flushM  = 1'b1;
                    w_cnt_d   = '0;
                    w_state_d = ST_MDU_WAIT;
                end else if (w_lu) begin
                    w_stallF = 1'b1;
                    w_stallD = 1'b1;
                    w_flushE = 1'b1;
                end
            end
            ST_MDU_WAIT: begin
                if (hz.mdu_done) begin
                    w_cnt_d   = '0;
                    w_state_d = ST_RUN;
                end else begin
                    w_stallF = 1'b1;
                    w_stallD = 1'b1;
                    w_stallE = 1'b1;
                    w_flushM = 1'b1;
                    if (r_cnt_q == c_CNT_LAST) begin
                        w_tmo_d   = 1'b1;
                        w_cnt_d   = '0;
                        w_state_d = ST_RUN;
                    end else begin
                        w_cnt_d = r_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: w_state_d = ST_RUN;
        endcase

        // Outputs sit at their idle values for as long as reset is held.
        if (!rst) begin
            w_stallF = 1'b0;
            w_stallD = 1'b0;
            w_stallE = 1'b0;
            w_flushD = 1'b0;
            w_flushE = 1'b0;
            w_flushM = 1'b0;
            w_fwd_a  = 2'b00;
            w_fwd_b  = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q <= ST_RUN;
            r_cnt_q   <= '0;
            r_tmo_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_tmo_q   <= w_tmo_d;
        end
    end

    assign hz.stallF      = w_stallF;
    assign hz.stallD      = w_stallD;
    assign hz.stallE      = w_stallE;
    assign hz.flushD      = w_flushD;
    assign hz.flushE      = w_flushE;
    assign hz.flushM      = w_flushM;
    assign hz.forwardAE   = w_fwd_a;
    assign hz.forwardBE   = w_fwd_b;
    assign hz.mdu_busy    = (r_state_q == ST_MDU_WAIT);
    assign hz.mdu_timeout = r_tmo_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_perf_stall_q, w_perf_stall_d;
    logic [31:0] r_perf_flush_q, w_perf_flush_d;

    always_comb begin
        w_perf_stall_d = r_perf_stall_q + {31'd0, w_stallF};
        w_perf_flush_d = r_perf_flush_q + {31'd0, w_flushE};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_stall_q <= '0;
            r_perf_flush_q <= '0;
        end else begin
            r_perf_stall_q <= w_perf_stall_d;
            r_perf_flush_q <= w_perf_flush_d;
        end
    end

    assign perf_stall_cnt = r_perf_stall_q;
    assign perf_flush_cnt = r_perf_flush_q;
`endif

endmodule

`default_nettype wire

// File: doc/hazard_sched_ctrl.md
Name: hazard_sched_ctrl

Overview:
Pipeline hazard scheduler for the 5-stage RV32 core. Decides forwarding, load-use stalls, redirect flushes and the wait for the multi-cycle multiply/divide unit (MDU). It drives the stall/flush inputs of every pipeline register, including stallF into the PC block. It consumes PCSE from the PC block as the taken-redirect indication.

Parameters:
REG_AW, 5, register address width
MDU_TIMEOUT, 64, max cycles in MDU_WAIT before a watchdog abort
CNT_W, 7, width of MDU wait counter (must hold MDU_TIMEOUT)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
rs1D, rs2D  in  REG_AW  source regs of instr in Decode
rs1E, rs2E, rdE  in  REG_AW  source/dest regs of instr in Execute
mem_readE  in  1  Execute instr is a load
mdu_startE  in  1  Execute instr issues an MDU op this cycle
mdu_done  in  1  MDU result valid (single-cycle pulse)
PCSE  in  1  branch/jump taken, redirect resolved in Execute
rdM, rdW  in  REG_AW  dest regs in Memory/Writeback
reg_writeM, reg_writeW  in  1  writeback enables in Memory/Writeback
stallF, stallD, stallE  out  1  hold the Fetch/PC, IF/ID and ID/EX registers
flushD, flushE, flushM  out  1  bubble the IF/ID, ID/EX and EX/MEM registers
forwardAE, forwardBE  out  2  operand select: 00 regfile, 01 from W, 10 from M
mdu_busy  out  1  FSM in MDU_WAIT
mdu_timeout  out  1  sticky watchdog error flag

Behaviour:
- FSM states: RUN (reset state), MDU_WAIT. State, counter and mdu_timeout are registered. All stall, flush and forward outputs are combinational from state plus inputs.
- Reset (rst=0, asynchronous):
  - state=RUN, counter=0, mdu_timeout=0.
  - All stall/flush outputs 0, forward outputs 00.
- Forwarding (both states), A path:
  - 10 if reg_writeM && rdM!=0 && rdM==rs1E.
  - Else 01 if reg_writeW && rdW!=0 && rdW==rs1E.
  - Else 00. M beats W when both match.
- B path: same rules using rs2E.
- RUN, load-use: lu = mem_readE && rdE!=0 && (rdE==rs1D || rdE==rs2D).
- RUN, priority 1: PCSE=1 -> flushD=1, flushE=1, no stalls.
  - Redirect overrides lu, because the Decode instr is wrong-path.
- RUN, priority 2: mdu_startE=1 (PCSE=0) -> next state MDU_WAIT, counter<=0.
  - Same cycle: stallF=stallD=stallE=1, flushM=1.
- RUN, priority 3: lu=1 -> stallF=stallD=1, flushE=1, for exactly one cycle. The next cycle re-evaluates with the load now in M.
- RUN, else: all stall/flush outputs 0.
- mdu_startE && PCSE together: an encoding error. The redirect wins, the MDU start is ignored, and the state stays RUN.
- MDU_WAIT, while mdu_done=0:
  - stallF=stallD=stallE=1, flushM=1, mdu_busy=1, counter increments.
  - PCSE ignored, lu ignored.
- MDU_WAIT, mdu_done=1: all stalls and flushM deassert in the same cycle so the result advances into M at the edge. Next state RUN.
- MDU_WAIT, counter==MDU_TIMEOUT-1 with mdu_done=0:
  - Set mdu_timeout (sticky until reset). Next state RUN.
  - Stalls release next cycle; the E result is garbage and software must check the flag.
- mdu_done in RUN: ignored, no effect.
- Reset asserted mid-MDU_WAIT: state returns to RUN immediately, outputs follow the reset values.
- Latency: redirect penalty is 2 bubbles. Load-use penalty is 1 cycle. MDU penalty is N+0 cycles, where N = cycles until mdu_done, counted from start.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined:
  - Adds output perf_stall_cnt [31:0] and output perf_flush_cnt [31:0].
  - perf_stall_cnt increments each cycle stallF=1. perf_flush_cnt increments each cycle flushE=1.
  - Both wrap at 2^32 and reset to 0.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Load-use: mem_readE=1, rdE=5, rs1D=5 in RUN -> stallF=stallD=flushE=1 for exactly 1 cycle, then 0. With rdE=0 -> no stall.
- Forwarding: reg_writeM=1, rdM=3, reg_writeW=1, rdW=3, rs1E=3, rs2E=3 -> forwardAE=forwardBE=10. With reg_writeM=0 -> 01. With rdM=rdW=0 -> 00.
- Redirect vs load-use: PCSE=1 and lu=1 same cycle -> flushD=flushE=1, stallF=0.
- MDU wait: mdu_startE=1, then mdu_done pulsed 7 cycles later -> stallF/D/E=1 and mdu_busy=1 for 7 cycles. All stalls 0 in the done cycle, state RUN the cycle after. PCSE=1 mid-wait has no effect.
- Watchdog: mdu_startE=1, mdu_done never asserted -> after 64 cycles mdu_timeout=1 and stays 1, stalls released, state RUN. A later MDU op completes normally with mdu_timeout still 1.
- Async reset: drop rst during MDU_WAIT between clock edges -> mdu_busy=0, all stalls 0, mdu_timeout=0 immediately, without waiting for a clock edge.
